// File: rtl/timepulse_sequencer.sv
// timepulse_sequencer: one-hot memory-cycle timepulse generator (T01..T12).
// Supports monitor stop at an MCT boundary, single-MCT stepping and GOJAM restart.
`default_nettype none

module timepulse_sequencer #(
   parameter int NUM_PULSES   = 12,
   parameter int PHASE_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run_en,
   input  logic                  mstp,
   input  logic                  mstrt,
   input  logic                  gojam,
   output logic [NUM_PULSES-1:0] tp,
   output logic                  mct_end,
   output logic                  stopped,
   output logic [CNT_W-1:0]      mct_count
);

   localparam int SUB_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
   localparam int IDX_W = (NUM_PULSES > 1) ? $clog2(NUM_PULSES) : 1;
   localparam logic [SUB_W-1:0]      SUB_LAST = SUB_W'(PHASE_CYCLES - 1);
   localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_PULSES - 1);
   localparam logic [NUM_PULSES-1:0] TP_FIRST = NUM_PULSES'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2,
      S_STEP = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [SUB_W-1:0] sub, sub_nxt;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic             mstrt_q;
   logic             running, running_nxt, at_boundary, mstrt_rise;

   assign running     = (state == S_RUN) || (state == S_STEP);
   assign at_boundary = running && (idx == IDX_LAST) && (sub == SUB_LAST);
   assign mstrt_rise  = mstrt && !mstrt_q;

   always_comb begin
      state_nxt = state;
      sub_nxt   = sub;
      idx_nxt   = idx;
      if (gojam) begin
         sub_nxt   = '0;
         idx_nxt   = '0;
         state_nxt = run_en ? S_RUN : S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (run_en) begin
                  state_nxt = S_RUN;
                  sub_nxt   = '0;
                  idx_nxt   = '0;
               end
            end
            S_RUN, S_STEP: begin
               if (at_boundary) begin
                  sub_nxt = '0;
                  idx_nxt = '0;
                  // run_en and mstp only matter here, so an MCT is never cut short
                  if (!run_en)   state_nxt = S_IDLE;
                  else if (mstp) state_nxt = S_HOLD;
                  else           state_nxt = S_RUN;
               end else if (sub == SUB_LAST) begin
                  sub_nxt = '0;
                  idx_nxt = idx + 1'b1;
               end else begin
                  sub_nxt = sub + 1'b1;
               end
            end
            S_HOLD: begin
               sub_nxt = '0;
               idx_nxt = '0;
               if (!run_en)         state_nxt = S_IDLE;
               else if (!mstp)      state_nxt = S_RUN;
               else if (mstrt_rise) state_nxt = S_STEP;
            end
            default: begin
               state_nxt = S_IDLE;
               sub_nxt   = '0;
               idx_nxt   = '0;
            end
         endcase
      end
      running_nxt = (state_nxt == S_RUN) || (state_nxt == S_STEP);
   end

   // Outputs are derived from the next-state values so they stay registered yet aligned.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         sub       <= '0;
         idx       <= '0;
         mstrt_q   <= 1'b0;
         tp        <= '0;
         mct_end   <= 1'b0;
         stopped   <= 1'b1;
         mct_count <= '0;
      end else begin
         state   <= state_nxt;
         sub     <= sub_nxt;
         idx     <= idx_nxt;
         mstrt_q <= mstrt;
         tp      <= running_nxt ? (TP_FIRST << idx_nxt) : '0;
         mct_end <= running_nxt && (idx_nxt == IDX_LAST) && (sub_nxt == SUB_LAST);
         stopped <= !running_nxt;
         if (at_boundary && !gojam) begin
            mct_count <= mct_count + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_timepulse_sequencer.sv
// Self-checking bench for timepulse_sequencer: directed scenarios plus random stimulus,
// checked against a position-in-MCT reference model (instance 0 defaults, instance 1 P=1, CNT_W=4).
`default_nettype none

module tb_timepulse_sequencer;

   localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_STEP = 3;
   localparam int NP = 12;
   localparam int MP [2] = '{2, 1};
   localparam int MMOD [2] = '{65536, 16};

   logic       clk = 1'b0;
   logic [1:0] rst = 2'b11;
   logic [1:0] run_en = 2'b00, mstp = 2'b00, mstrt = 2'b00, gojam = 2'b00;

   logic [11:0] tp0, tp1;
   logic        end0, end1, stp0, stp1;
   logic [15:0] cnt0;
   logic [3:0]  cnt1;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;

   int m_mode [2] = '{0, 0};
   int m_pos  [2] = '{0, 0};
   int m_cnt  [2] = '{0, 0};
   int m_prev [2] = '{0, 0};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   timepulse_sequencer dut0 (
      .clk(clk), .rst(rst[0]), .run_en(run_en[0]), .mstp(mstp[0]), .mstrt(mstrt[0]),
      .gojam(gojam[0]), .tp(tp0), .mct_end(end0), .stopped(stp0), .mct_count(cnt0)
   );

   timepulse_sequencer #(.NUM_PULSES(12), .PHASE_CYCLES(1), .CNT_W(4)) dut1 (
      .clk(clk), .rst(rst[1]), .run_en(run_en[1]), .mstp(mstp[1]), .mstrt(mstrt[1]),
      .gojam(gojam[1]), .tp(tp1), .mct_end(end1), .stopped(stp1), .mct_count(cnt1)
   );

   // Reference model: a mode plus a single position counter across the whole MCT.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         int mode, pos, cnt, last;
         bit rise;
         mode = m_mode[k];
         pos  = m_pos[k];
         cnt  = m_cnt[k];
         last = NP * MP[k] - 1;
         rise = mstrt[k] && (m_prev[k] == 0);
         if (rst[k]) begin
            mode = M_IDLE; pos = 0; cnt = 0;
         end else if (gojam[k]) begin
            pos  = 0;
            mode = run_en[k] ? M_RUN : M_IDLE;
         end else if (mode == M_IDLE) begin
            if (run_en[k]) begin mode = M_RUN; pos = 0; end
         end else if (mode == M_HOLD) begin
            if (!run_en[k])     mode = M_IDLE;
            else if (!mstp[k])  begin mode = M_RUN;  pos = 0; end
            else if (rise)      begin mode = M_STEP; pos = 0; end
         end else begin
            if (pos == last) begin
               cnt = (cnt + 1) % MMOD[k];
               pos = 0;
               if (!run_en[k])   mode = M_IDLE;
               else if (mstp[k]) mode = M_HOLD;
               else              mode = M_RUN;
            end else begin
               pos = pos + 1;
            end
         end
         m_mode[k] <= mode;
         m_pos[k]  <= pos;
         m_cnt[k]  <= cnt;
         m_prev[k] <= rst[k] ? 0 : int'(mstrt[k]);
      end
   end

   function automatic bit m_running(int k);
      return (m_mode[k] == M_RUN) || (m_mode[k] == M_STEP);
   endfunction

   function automatic logic [11:0] exp_tp(int k);
      logic [11:0] one;
      one = 12'd1;
      if (m_running(k)) return one << (m_pos[k] / MP[k]);
      return 12'd0;
   endfunction

   function automatic logic exp_end(int k);
      return m_running(k) && (m_pos[k] == NP * MP[k] - 1);
   endfunction

   function automatic logic exp_stp(int k);
      return !m_running(k);
   endfunction

   // Invariant: one-hot while running, all-zero while stopped.
   always @(negedge clk) begin
      compared += 2;
      if (!stp0) assert ($onehot(tp0)) else begin
         mismatched++; $display("FAIL onehot0: tp=%h while running, required exactly one bit", tp0);
      end
      else assert (tp0 == 12'd0) else begin
         mismatched++; $display("FAIL zero0: tp=%h while stopped, required 000", tp0);
      end
      if (!stp1) assert ($onehot(tp1)) else begin
         mismatched++; $display("FAIL onehot1: tp=%h while running, required exactly one bit", tp1);
      end
      else assert (tp1 == 12'd0) else begin
         mismatched++; $display("FAIL zero1: tp=%h while stopped, required 000", tp1);
      end
   end

   task automatic test_reset;
      rst = 2'b11;
      run_en = 2'($urandom); mstp = 2'($urandom); mstrt = 2'($urandom); gojam = 2'($urandom);
      repeat (3) begin
         @(negedge clk);
         compared++;
         if ({tp0, end0, stp0, cnt0} !== {12'h000, 1'b0, 1'b1, 16'd0}) begin
            mismatched++;
            $display("FAIL reset: tp=%h end=%b stopped=%b cnt=%0d, want 000/0/1/0", tp0, end0, stp0, cnt0);
         end
      end
      run_en = 2'b00; mstp = 2'b00; mstrt = 2'b00; gojam = 2'b00;
   endtask

   task automatic test_basic_run;
      rst[0] = 1'b0; run_en[0] = 1'b1;
      for (int c = 1; c <= 26; c++) begin
         @(negedge clk);
         compared++;
         if ({tp0, end0, stp0, cnt0} !== {exp_tp(0), exp_end(0), exp_stp(0), 16'(m_cnt[0])}) begin
            mismatched++;
            $display("FAIL basic_run c%0d: tp=%h end=%b stopped=%b cnt=%0d, want tp=%h end=%b stopped=%b cnt=%0d",
                     c, tp0, end0, stp0, cnt0, exp_tp(0), exp_end(0), exp_stp(0), m_cnt[0]);
         end
         if (c == 1 || c == 3 || c == 23 || c == 24 || c == 25) begin
            logic [11:0] want_tp;
            logic        want_end;
            want_tp  = (c == 1 || c == 25) ? 12'h001 : (c == 3) ? 12'h002 : 12'h800;
            want_end = (c == 24);
            compared++;
            if (tp0 !== want_tp || end0 !== want_end || (c == 25 && cnt0 !== 16'd1)) begin
               mismatched++;
               $display("FAIL basic_cycle c%0d: tp=%h end=%b cnt=%0d, want tp=%h end=%b", c, tp0, end0, cnt0,
                        want_tp, want_end);
            end
         end
      end
   endtask

   task automatic test_monitor_stop;
      bit raised = 0;
      for (int c = 0; c < 40; c++) begin
         if (!raised && m_mode[0] == M_RUN && m_pos[0] / 2 == 4) begin
            mstp[0] = 1'b1; raised = 1;
         end
         @(negedge clk);
         compared++;
         if ({tp0, end0, stp0, cnt0} !== {exp_tp(0), exp_end(0), exp_stp(0), 16'(m_cnt[0])}) begin
            mismatched++;
            $display("FAIL monitor_stop c%0d: tp=%h end=%b stopped=%b cnt=%0d, want tp=%h end=%b stopped=%b cnt=%0d",
                     c, tp0, end0, stp0, cnt0, exp_tp(0), exp_end(0), exp_stp(0), m_cnt[0]);
         end
      end
      compared++;
      if (tp0 !== 12'h000 || stp0 !== 1'b1 || cnt0 !== 16'd2) begin
         mismatched++;
         $display("FAIL hold_entry: tp=%h stopped=%b cnt=%0d, want 000/1/2", tp0, stp0, cnt0);
      end
   endtask

   task automatic test_step;
      for (int s = 0; s < 2; s++) begin
         int ends = 0, live = 0;
         for (int c = 0; c < 40; c++) begin
            mstrt[0] = (s == 0) ? (c < 5) : (c < 1);
            @(negedge clk);
            ends += int'(end0);
            live += int'(!stp0);
            compared++;
            if ({tp0, end0, stp0, cnt0} !== {exp_tp(0), exp_end(0), exp_stp(0), 16'(m_cnt[0])}) begin
               mismatched++;
               $display("FAIL step s%0d c%0d: tp=%h end=%b stopped=%b cnt=%0d, want tp=%h end=%b stopped=%b cnt=%0d",
                        s, c, tp0, end0, stp0, cnt0, exp_tp(0), exp_end(0), exp_stp(0), m_cnt[0]);
            end
         end
         compared++;
         if (ends != 1 || live != 24 || stp0 !== 1'b1 || cnt0 !== 16'(3 + s)) begin
            mismatched++;
            $display("FAIL step_once s%0d: ends=%0d running=%0d stopped=%b cnt=%0d, want 1/24/1/%0d",
                     s, ends, live, stp0, cnt0, 3 + s);
         end
      end
   endtask

   task automatic test_gojam;
      mstp[0] = 1'b0;
      for (int g = 0; g < 2; g++) begin
         bit found = 0;
         for (int c = 0; c < 80 && !found; c++) begin
            @(negedge clk);
            found = (m_mode[0] == M_RUN && m_pos[0] == 13);
         end
         compared++;
         if (!found) begin
            mismatched++; $display("FAIL gojam_wait g%0d: T07 not reached within 80 cycles", g);
         end
         gojam[0] = 1'b1; run_en[0] = (g == 0);
         @(negedge clk);
         gojam[0] = 1'b0;
         compared++;
         if (g == 0 && (tp0 !== 12'h001 || stp0 !== 1'b0 || end0 !== 1'b0 || cnt0 !== 16'd4)) begin
            mismatched++;
            $display("FAIL gojam_run: tp=%h stopped=%b end=%b cnt=%0d, want 001/0/0/4", tp0, stp0, end0, cnt0);
         end
         if (g == 1 && (tp0 !== 12'h000 || stp0 !== 1'b1 || cnt0 !== 16'd4)) begin
            mismatched++;
            $display("FAIL gojam_idle: tp=%h stopped=%b cnt=%0d, want 000/1/4", tp0, stp0, cnt0);
         end
         for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            compared++;
            if (tp0 !== ((g == 0) ? ((c == 0) ? 12'h001 : 12'h002) : 12'h000)) begin
               mismatched++;
               $display("FAIL gojam_after g%0d c%0d: tp=%h, want %h", g, c, tp0,
                        (g == 0) ? ((c == 0) ? 12'h001 : 12'h002) : 12'h000);
            end
         end
      end
   endtask

   task automatic test_reset_in_step;
      bit found = 0;
      run_en[0] = 1'b1; mstp[0] = 1'b1; mstrt[0] = 1'b0;
      for (int c = 0; c < 120 && !found; c++) begin
         mstrt[0] = (m_mode[0] == M_HOLD);
         @(negedge clk);
         found = (m_mode[0] == M_STEP && m_pos[0] == 16);
      end
      compared++;
      if (!found) begin
         mismatched++; $display("FAIL step_wait: T09 of a STEP not reached within 120 cycles");
      end
      rst[0] = 1'b1;
      @(negedge clk);
      compared++;
      if ({tp0, end0, stp0, cnt0} !== {12'h000, 1'b0, 1'b1, 16'd0}) begin
         mismatched++;
         $display("FAIL reset_in_step: tp=%h end=%b stopped=%b cnt=%0d, want 000/0/1/0", tp0, end0, stp0, cnt0);
      end
      rst[0] = 1'b0; run_en[0] = 1'b0; mstp[0] = 1'b0; mstrt[0] = 1'b0;
      @(negedge clk);
      mstrt[0] = 1'b1;
      repeat (5) begin
         @(negedge clk);
         compared++;
         if (tp0 !== 12'h000 || stp0 !== 1'b1) begin
            mismatched++; $display("FAIL idle_mstrt: tp=%h stopped=%b, want 000/1", tp0, stp0);
         end
      end
      mstrt[0] = 1'b0;
   endtask

   task automatic test_count_wrap;
      rst[1] = 1'b0; run_en[1] = 1'b1; mstp[1] = 1'b0; mstrt[1] = 1'b0; gojam[1] = 1'b0;
      for (int c = 1; c <= 12 * 17 + 2; c++) begin
         @(negedge clk);
         compared++;
         if ({tp1, end1, stp1, cnt1} !== {exp_tp(1), exp_end(1), exp_stp(1), 4'(m_cnt[1])}) begin
            mismatched++;
            $display("FAIL wrap c%0d: tp=%h end=%b stopped=%b cnt=%0d, want tp=%h end=%b stopped=%b cnt=%0d",
                     c, tp1, end1, stp1, cnt1, exp_tp(1), exp_end(1), exp_stp(1), m_cnt[1]);
         end
         if (c == 12) begin
            compared++;
            if (tp1 !== 12'h800 || end1 !== 1'b1) begin
               mismatched++; $display("FAIL p1_end: tp=%h end=%b, want 800/1", tp1, end1);
            end
         end
         if (c == 12 * 15 + 1 || c == 12 * 16 + 1 || c == 12 * 17 + 1) begin
            logic [3:0] want;
            want = (c == 12 * 15 + 1) ? 4'd15 : (c == 12 * 16 + 1) ? 4'd0 : 4'd1;
            compared++;
            if (cnt1 !== want) begin
               mismatched++; $display("FAIL cnt_wrap c%0d: cnt=%0d, want %0d", c, cnt1, want);
            end
         end
      end
   endtask

   task automatic test_random;
      run_en = 2'b11; mstp = 2'b00; mstrt = 2'b00; gojam = 2'b00; rst = 2'b00;
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < 2; k++) begin
            if ($urandom_range(0, 39) == 0) run_en[k] = ~run_en[k];
            if ($urandom_range(0, 14) == 0) mstp[k] = ~mstp[k];
            if ($urandom_range(0, 3) == 0)  mstrt[k] = ~mstrt[k];
            gojam[k] = ($urandom_range(0, 29) == 0);
            rst[k]   = ($urandom_range(0, 299) == 0);
         end
         @(negedge clk);
         compared += 2;
         if ({tp0, end0, stp0, cnt0} !== {exp_tp(0), exp_end(0), exp_stp(0), 16'(m_cnt[0])}) begin
            mismatched++;
            $display("FAIL random0 c%0d: tp=%h end=%b stopped=%b cnt=%0d, want tp=%h end=%b stopped=%b cnt=%0d",
                     c, tp0, end0, stp0, cnt0, exp_tp(0), exp_end(0), exp_stp(0), m_cnt[0]);
         end
         if ({tp1, end1, stp1, cnt1} !== {exp_tp(1), exp_end(1), exp_stp(1), 4'(m_cnt[1])}) begin
            mismatched++;
            $display("FAIL random1 c%0d: tp=%h end=%b stopped=%b cnt=%0d, want tp=%h end=%b stopped=%b cnt=%0d",
                     c, tp1, end1, stp1, cnt1, exp_tp(1), exp_end(1), exp_stp(1), m_cnt[1]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_run();
      test_monitor_stop();
      test_step();
      test_gojam();
      test_reset_in_step();
      test_count_wrap();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/timepulse_sequencer.md
Name: timepulse_sequencer

Overview:
- Generates the one-hot memory-cycle timepulses T01..T12 that strobe the NOR-gate datapath.
- Each timepulse lasts PHASE_CYCLES clocks; a full sequence is one memory cycle time (MCT).
- Provides monitor-stop (hold at an MCT boundary) and single-MCT step control, plus a restart (GOJAM) input that realigns the sequence to T01.
- Sits between the clock scaler and all timepulse-gated logic.

Parameters:
- NUM_PULSES, 12: timepulses per MCT; width of tp.
- PHASE_CYCLES, 2: clocks each timepulse is held; must be >= 1.
- CNT_W, 16: width of mct_count.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- run_en  input  1  level; enables sequencing. Sampled at the MCT boundary while running.
- mstp  input  1  level; monitor stop request. Sampled at the MCT boundary.
- mstrt  input  1  step request; rising edge detected internally; honoured only in HOLD.
- gojam  input  1  restart; synchronous, one-cycle pulse or level.
- tp  output  NUM_PULSES  one-hot timepulses; bit 0 = T01.
- mct_end  output  1  high during the last clock of T12.
- stopped  output  1  high in IDLE or HOLD.
- mct_count  output  CNT_W  completed MCTs; wraps modulo 2^CNT_W.

Behaviour:
- All outputs are registered.
- Internal counters:
  - sub: 0..PHASE_CYCLES-1, clocks within the current timepulse.
  - idx: 0..NUM_PULSES-1, current timepulse.
- The MCT boundary is the cycle where RUN or STEP has idx=NUM_PULSES-1 and sub=PHASE_CYCLES-1.
- States: IDLE, RUN, HOLD, STEP.
- Reset (rst=1), highest priority:
  - state=IDLE, tp=0, mct_end=0, stopped=1, mct_count=0, sub=idx=0.
  - The mstrt edge detector history is cleared to 0.
- gojam=1 (rst=0), second priority:
  - Next cycle: sub=0, idx=0, mct_end=0.
  - If run_en=1: state=RUN, tp=T01, stopped=0.
  - If run_en=0: state=IDLE, tp=0, stopped=1.
  - mct_count is not changed.
  - A step in progress is abandoned.
- IDLE:
  - tp=0.
  - run_en=1 -> next cycle state=RUN, tp=T01, sub=0, stopped=0.
  - Latency from run_en to T01 is 1 clock.
- RUN and STEP:
  - tp holds bit idx for exactly PHASE_CYCLES clocks.
  - When sub wraps, idx increments and tp shifts left by one.
  - mct_end=1 only in the boundary cycle.
  - In the boundary cycle, mct_count increments, taking effect the next cycle.
- Boundary decision in RUN, evaluated in priority order:
  - run_en=0 -> IDLE, tp=0.
  - else mstp=1 -> HOLD, tp=0.
  - else wrap to T01 and stay in RUN.
- Boundary decision in STEP:
  - run_en=0 -> IDLE.
  - else mstp=1 -> HOLD.
  - else RUN, wrapping to T01.
  - Net effect: STEP runs exactly one MCT.
- mstp and run_en changes mid-MCT have no effect until the boundary. An MCT is never truncated except by rst or gojam.
- HOLD:
  - tp=0, stopped=1.
  - run_en=0 -> IDLE.
  - else mstp=0 -> next cycle RUN, tp=T01.
  - else a rising edge on mstrt (mstrt=1 and previous-cycle mstrt=0) -> next cycle STEP, tp=T01, stopped=0.
  - mstrt held high produces one step only.
  - An mstrt edge outside HOLD is ignored, not queued.
- PHASE_CYCLES=1: tp advances every clock. mct_end coincides with T12.
- mct_count wraps from 2^CNT_W-1 to 0 with no flag.
- Invariant: tp has zero bits set in IDLE/HOLD and exactly one bit set in RUN/STEP.

Test Plan:
1. Reset then run_en=1 at cycle 0 (defaults):
   - tp=12'h001 from cycle 1, 12'h002 from cycle 3, ..., 12'h800 in cycles 23-24.
   - mct_end=1 in cycle 24 only; tp=12'h001 at cycle 25.
   - mct_count=1 at cycle 25.
2. mstp raised mid-MCT at T05:
   - The sequence completes through T12.
   - After the boundary: tp=0, stopped=1, state HOLD.
   - mct_count increments once.
3. In HOLD, mstrt pulses high for 5 cycles:
   - Exactly one 24-cycle MCT with a single mct_end, then HOLD again.
   - A second mstrt edge gives one more MCT; total mct_count +2.
4. gojam asserted during T07 with run_en=1:
   - Next cycle tp=12'h001 with sub restarted; mct_count unchanged.
   - Repeat with run_en=0: tp=0, stopped=1.
5. rst asserted during T09 of a STEP:
   - Next cycle all outputs take reset values.
   - An mstrt edge in IDLE produces no tp activity.
6. CNT_W=4, run 17 MCTs:
   - mct_count reads 15, then 0, then 1.
   - tp is one-hot in every running cycle (checked by assertion).
